// File: rtl/glitch_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : glitch_burst_gen
// Purpose  : Armed, edge-triggered glitch burst generator. After an arm
//            request the block waits for a synchronised trigger edge, then
//            issues N pulses of W cycles separated by G low cycles, starting
//            cfg_delay cycles after the edge is detected.
// Revision : 1.0 - initial release
// ============================================================================
module glitch_burst_gen #(
    parameter int CNT_W       = 32,
    parameter int NPULSE_W    = 8,
    parameter int SYNC_STAGES = 2     // must be at least 2
) (
    input  logic                CLK,
    input  logic                RESETB,
    input  logic                trigger,
    input  logic                trig_edge,
    input  logic                arm,
    input  logic                abort,
    input  logic [CNT_W-1:0]    cfg_delay,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic [CNT_W-1:0]    cfg_gap,
    input  logic [NPULSE_W-1:0] cfg_count,
    output logic                glitch,
    output logic                armed,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0]    C_CNT_ONE = CNT_W'(1);
    localparam logic [NPULSE_W-1:0] C_NP_ONE  = NPULSE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic                   prev_q,  prev_d;
    logic                   edge_q,  edge_d;
    logic [CNT_W-1:0]       delay_q, delay_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic [CNT_W-1:0]       gap_q,   gap_d;
    logic [NPULSE_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [NPULSE_W-1:0]    left_q,  left_d;
    logic                   glitch_q, glitch_d;
    logic                   w_level;
    logic                   w_detect;

    // Edge detect on the synchronised level against its previous value;
    // a level that is merely present (no transition) never fires.
    always_comb begin
        w_level  = sync_q[SYNC_STAGES-1];
        w_detect = edge_q ? (w_level & ~prev_q) : (~w_level & prev_q);
    end

    // Next-state, counter and config-latch logic; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[SYNC_STAGES-2:0], trigger};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_d   = edge_q;
        delay_d  = delay_q;
        width_d  = width_q;
        gap_d    = gap_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        left_d   = left_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    // Zero width/gap/count are stored as 1 so the burst
                    // logic never has to special-case them.
                    delay_d = cfg_delay;
                    width_d = (cfg_width == '0) ? C_CNT_ONE : cfg_width;
                    gap_d   = (cfg_gap   == '0) ? C_CNT_ONE : cfg_gap;
                    count_d = (cfg_count == '0) ? C_NP_ONE  : cfg_count;
                    edge_d  = trig_edge;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_detect) begin
                    left_d = count_q;
                    if (delay_q == '0) begin
                        state_d = S_PULSE;
                        cnt_d   = width_q;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = delay_q;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q <= C_CNT_ONE) begin
                    state_d = S_PULSE;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q <= C_CNT_ONE) begin
                    left_d = left_q - C_NP_ONE;
                    if (left_q <= C_NP_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = gap_q;
                    end
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q <= C_CNT_ONE) begin
                    state_d = S_PULSE;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - C_CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            left_d  = '0;
        end

        glitch_d = (state_d == S_PULSE);
    end

    // State, synchroniser and datapath registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            edge_q   <= 1'b0;
            delay_q  <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            left_q   <= '0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            edge_q   <= edge_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            glitch_q <= glitch_d;
        end
    end

    assign glitch = glitch_q;
    assign armed  = (state_q == S_ARMED);
    assign busy   = (state_q == S_DELAY) || (state_q == S_PULSE) || (state_q == S_GAP);
    assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_glitch_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_glitch_burst_gen
// Purpose  : Self-checking bench for glitch_burst_gen (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_glitch_burst_gen;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic        trigger, trig_edge, arm, abort;
    logic [31:0] cfg_delay, cfg_width, cfg_gap;
    logic [7:0]  cfg_count;
    logic        glitch, armed, busy, done;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] w;
        logic [31:0] g;
        logic [7:0]  c;
        logic        e;
        int          rise;    // index of first glitch high, 0 = first busy cycle
        int          high;    // total glitch-high cycles
        int          pulses;  // number of rising edges on glitch
        int          dn;      // index of done strobe
    } vec_t;

    vec_t vecs [5];

    glitch_burst_gen dut (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .trigger   (trigger),
        .trig_edge (trig_edge),
        .arm       (arm),
        .abort     (abort),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .glitch    (glitch),
        .armed     (armed),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic do_arm(input logic [31:0] d, input logic [31:0] w, input logic [31:0] g,
                          input logic [7:0] c, input logic e);
        cfg_delay = d; cfg_width = w; cfg_gap = g; cfg_count = c; trig_edge = e;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_after_arm", armed, 1);
    endtask

    // Drive the active trigger level, confirm detect latency, then record the
    // burst over a fixed window and compare against the expected shape.
    task automatic fire_observe(input logic lvl, input int rise, input int high,
                                input int pulses, input int dn, input bit disturb);
        int  r, h, p, di, dc, bc;
        bit  pg;
        r = -1; h = 0; p = 0; di = -1; dc = 0; bc = 0; pg = 1'b0;
        trigger = lvl;
        tick(); tick();
        check("busy_before_detect", busy, 0);
        tick();
        check("busy_after_detect", busy, 1);
        for (int i = 0; i < 40; i++) begin
            if (glitch) begin
                h++;
                if (!pg) begin
                    p++;
                    if (r < 0) r = i;
                end
            end
            pg = glitch;
            if (done) begin
                dc++;
                if (di < 0) di = i;
            end
            if (busy) bc++;
            if (disturb && i < dn) begin
                cfg_delay = $urandom; cfg_width = $urandom;
                cfg_gap   = $urandom; cfg_count = 8'($urandom);
                arm       = i[0];
                trigger   = ~trigger;
            end else begin
                arm = 1'b0;
            end
            tick();
        end
        check("first_rise", r, rise);
        check("high_cycles", h, high);
        check("pulse_count", p, pulses);
        check("done_index", di, dn);
        check("done_cycles", dc, 1);
        check("busy_cycles", bc, dn);
        check("armed_after_burst", armed, 0);
    endtask

    initial begin
        int cnt;
        //          d   w  g  c  e  rise high pulses done
        vecs[0] = '{32'd10, 32'd3, 32'd0, 8'd1, 1'b1, 10, 3, 1, 13};
        vecs[1] = '{32'd0,  32'd2, 32'd4, 8'd3, 1'b1,  0, 6, 3, 14};
        vecs[2] = '{32'd5,  32'd0, 32'd0, 8'd0, 1'b1,  5, 1, 1,  6};
        vecs[3] = '{32'd1,  32'd1, 32'd1, 8'd4, 1'b1,  1, 4, 4,  8};
        vecs[4] = '{32'd2,  32'd4, 32'd3, 8'd2, 1'b0,  2, 8, 2, 13};

        RESETB = 1'b0; trigger = 1'b0; trig_edge = 1'b1; arm = 1'b0; abort = 1'b0;
        cfg_delay = '0; cfg_width = '0; cfg_gap = '0; cfg_count = '0;
        #1;
        check("reset_glitch", glitch, 0);
        check("reset_armed",  armed,  0);
        check("reset_busy",   busy,   0);
        check("reset_done",   done,   0);
        tick(); tick(); tick();
        RESETB = 1'b1;
        tick();

        // Table-driven bursts
        for (int v = 0; v < 5; v++) begin
            trigger = ~vecs[v].e;
            tick(); tick(); tick(); tick();
            do_arm(vecs[v].d, vecs[v].w, vecs[v].g, vecs[v].c, vecs[v].e);
            fire_observe(vecs[v].e, vecs[v].rise, vecs[v].high,
                         vecs[v].pulses, vecs[v].dn, 1'b0);
        end

        // Falling-edge select: a rising edge must be ignored
        trigger = 1'b0;
        tick(); tick(); tick(); tick();
        do_arm(32'd3, 32'd1, 32'd0, 8'd1, 1'b0);
        trigger = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rise_ignored_busy",  busy,  0);
        check("rise_ignored_armed", armed, 1);
        fire_observe(1'b0, 3, 1, 1, 4, 1'b0);

        // Level already matching at arm time does not trigger; abort and
        // abort-with-arm both leave the block idle
        trigger = 1'b1;
        tick(); tick(); tick(); tick();
        do_arm(32'd0, 32'd1, 32'd0, 8'd1, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("level_no_trigger", busy, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_clears_armed", armed, 0);
        abort = 1'b1; arm = 1'b1;
        tick();
        abort = 1'b0; arm = 1'b0;
        check("abort_beats_arm_armed", armed, 0);
        check("abort_beats_arm_busy",  busy,  0);

        // Abort during the second pulse of a 4-pulse burst
        trigger = 1'b0;
        tick(); tick(); tick(); tick();
        do_arm(32'd0, 32'd3, 32'd2, 8'd4, 1'b1);
        trigger = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 6; i++) tick();
        check("second_pulse_high", glitch, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_glitch", glitch, 0);
        check("abort_busy",   busy,   0);
        check("abort_armed",  armed,  0);
        check("abort_done",   done,   0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (glitch || done || busy) cnt++;
            tick();
        end
        check("abort_stays_quiet", cnt, 0);
        trigger = 1'b0;
        tick(); tick(); tick(); tick();
        do_arm(32'd0, 32'd2, 32'd4, 8'd3, 1'b1);
        fire_observe(1'b1, 0, 6, 3, 14, 1'b0);

        // Asynchronous reset mid-delay with a toggling trigger
        trigger = 1'b0;
        tick(); tick(); tick(); tick();
        do_arm(32'd20, 32'd1, 32'd0, 8'd1, 1'b1);
        trigger = 1'b1;
        tick(); tick(); tick();
        check("delay_busy", busy, 1);
        tick(); tick(); tick();
        trigger = 1'b0;
        RESETB = 1'b0;
        #1;
        check("rst_glitch", glitch, 0);
        check("rst_armed",  armed,  0);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        tick();
        RESETB = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            trigger = ~trigger;
            tick();
            if (glitch || busy || armed || done) cnt++;
        end
        check("post_reset_quiet", cnt, 0);

        // Arm accepted on the first clock edge after reset release
        trigger = 1'b0;
        RESETB = 1'b0;
        tick();
        cfg_delay = 32'd2; cfg_width = 32'd2; cfg_gap = 32'd1; cfg_count = 8'd2;
        trig_edge = 1'b1;
        RESETB = 1'b1; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_first_edge", armed, 1);
        tick(); tick();
        fire_observe(1'b1, 2, 4, 2, 7, 1'b0);

        // Config changes, arm toggles and trigger toggles while busy
        trigger = 1'b0;
        tick(); tick(); tick(); tick();
        do_arm(32'd0, 32'd2, 32'd4, 8'd3, 1'b1);
        fire_observe(1'b1, 0, 6, 3, 14, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/glitch_burst_gen.md
GLITCH_BURST_GEN -- requirements
Module: glitch_burst_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, meaning width of the delay, width and gap counters and their config inputs.
REQ-002 The block SHALL have parameter NPULSE_W, default 8, meaning width of the pulse-count config input.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2 (minimum 2), meaning flip-flop depth of the trigger synchroniser.
REQ-004 CLK  input  1  single clock; all logic on its rising edge.
REQ-005 RESETB  input  1  reset, asynchronous, active-low.
REQ-006 trigger  input  1  external asynchronous trigger.
REQ-007 trig_edge  input  1  trigger edge select: 1 = rising, 0 = falling.
REQ-008 arm  input  1  single-cycle request to latch config and wait for a trigger.
REQ-009 abort  input  1  single-cycle request to cancel any operation.
REQ-010 cfg_delay  input  CNT_W  cycles from trigger detect to first pulse.
REQ-011 cfg_width  input  CNT_W  glitch high time in cycles.
REQ-012 cfg_gap  input  CNT_W  low time between pulses in cycles.
REQ-013 cfg_count  input  NPULSE_W  number of pulses per burst.
REQ-014 glitch  output  1  registered glitch pulse output.
REQ-015 armed  output  1  high while waiting for a trigger.
REQ-016 busy  output  1  high from trigger detect until burst completion.
REQ-017 done  output  1  one-cycle completion strobe.

Function
REQ-018 States SHALL be IDLE, ARMED, DELAY, PULSE, GAP, DONE; any unused encoding SHALL return to IDLE next cycle.
REQ-019 trigger SHALL pass through SYNC_STAGES flops; a detect pulse is asserted the cycle the synchronised level shows the edge selected by trig_edge.
REQ-020 IDLE with arm=1: latch cfg_delay, cfg_width, cfg_gap, cfg_count and trig_edge; go ARMED; armed=1 from next cycle.
REQ-021 Latched values SHALL be used for the whole burst; cfg input changes after arm have no effect.
REQ-022 cfg_width=0, cfg_gap=0 and cfg_count=0 SHALL each be treated as 1; cfg_delay=0 is legal.
REQ-023 ARMED with detect at cycle T: go DELAY; armed=0 and busy=1 from T+1.
REQ-024 glitch SHALL first rise at cycle T+1+cfg_delay and stay high exactly W cycles (W = effective width).
REQ-025 Between pulses glitch SHALL be low exactly G cycles (G = effective gap); exactly N pulses issued (N = effective count).
REQ-026 The cycle after the last pulse falls: state DONE, done=1 for one cycle, busy=0 from that cycle, then IDLE.
REQ-027 Counters SHALL not wrap: all-ones cfg_delay/cfg_width/cfg_gap give 2^CNT_W-1 cycles exactly.
REQ-028 arm outside IDLE and trigger edges outside ARMED SHALL be ignored (no retrigger, no queuing).
REQ-029 abort in any state: next cycle IDLE, glitch=0, armed=0, busy=0, done stays 0.
REQ-030 abort and arm in the same cycle: abort wins, block ends in IDLE.
REQ-031 Trigger level already matching the selected edge at arm time SHALL not trigger; a fresh edge is required.

Reset
REQ-032 RESETB low SHALL immediately force IDLE, glitch=0, armed=0, busy=0, done=0, all counters and synchroniser flops 0, including mid-pulse.
REQ-033 After RESETB deasserts, the block SHALL accept arm on the first rising CLK edge.

Verification
REQ-034 Arm with delay=10, width=3, gap=0, count=1, rising; pulse trigger -> glitch high exactly cycles T+11..T+13, done at T+14.
REQ-035 Arm with delay=0, width=2, gap=4, count=3 -> glitch pattern 2 high, 4 low, 2 high, 4 low, 2 high; done one cycle after final fall.
REQ-036 trig_edge=0, trigger rising then falling -> no action on rise; burst timed from the falling-edge detect.
REQ-037 abort during second pulse of a count=4 burst -> glitch 0 next cycle, no done, later arm+trigger gives a full burst.
REQ-038 RESETB asserted mid-DELAY with trigger toggling -> all outputs 0 immediately; no glitch until re-armed and triggered.
REQ-039 Change cfg_* and toggle arm during busy -> burst timing unchanged, no extra pulses.
